// File: rtl/wb_stage.sv
// wb_stage: write-back stage, the producer side of the register-file write port.
// Latency: ALU/call write 1 cycle after accept; load write 1 cycle after ldValid.
// Backpressure: inReady is low while waiting for load data (WAIT_LD); upstream holds its inputs.
//
// Ports: clk/rst (sync, active-high); inValid/inReady handshake from the memory-access stage;
//   instruction (rd=[25:22]), PC, aluR, isWb, isLd, isCall qualify the retiring instruction;
//   ldValid/ldR deliver late load data; isWbOut/writeRegAddr/writeData form the register-file
//   write port; fwdValid/fwdAddr/fwdData bypass to operand fetch; ldErr is the sticky load-timeout
//   flag; retCount counts retirements.
// Build option: define WB_FWD_EN to drive the forwarding outputs from the write port;
//   without it fwdValid/fwdAddr/fwdData are tied to zero.
module wb_stage #(
  parameter int LD_TIMEOUT = 16,
  parameter int CNT_W      = 16,
  parameter int RET_REG    = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inValid,
  output logic             inReady,
  input  logic [31:0]      instruction,
  input  logic [31:0]      PC,
  input  logic [31:0]      aluR,
  input  logic             isWb,
  input  logic             isLd,
  input  logic             isCall,
  input  logic             ldValid,
  input  logic [31:0]      ldR,
  output logic             isWbOut,
  output logic [3:0]       writeRegAddr,
  output logic [31:0]      writeData,
  output logic             fwdValid,
  output logic [3:0]       fwdAddr,
  output logic [31:0]      fwdData,
  output logic             ldErr,
  output logic [CNT_W-1:0] retCount
);

  localparam int TW = (LD_TIMEOUT > 1) ? $clog2(LD_TIMEOUT) : 1;

  typedef enum logic [0:0] {S_IDLE, S_WAIT_LD} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [TW-1:0]    r_cnt;
  logic [3:0]       r_rd;
  logic             r_wb;
  logic [3:0]       r_addr;
  logic [31:0]      r_data;
  logic             r_ld_err;
  logic [CNT_W-1:0] r_ret;

  logic             w_accept;
  logic             w_expired;
  logic             w_wr_en;
  logic [3:0]       w_wr_addr;
  logic [31:0]      w_wr_data;
  logic             w_ld_start;
  logic             w_abort;
  logic             w_retire;
  logic             w_unused;

  // Only the rd field of the instruction word matters here.
  assign w_unused  = ^{instruction[31:26], instruction[21:0]};

  assign inReady   = (r_state == S_IDLE);
  assign w_accept  = inValid && inReady;
  // Last wait cycle: counter started at 0 on entry, so this is the LD_TIMEOUT-th cycle in WAIT_LD.
  assign w_expired = (r_cnt == TW'(LD_TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_accept && !isCall && isWb && isLd) w_state_nxt = S_WAIT_LD;
      S_WAIT_LD: if (ldValid || w_expired)                w_state_nxt = S_IDLE;
      default:                                            w_state_nxt = S_IDLE;
    endcase
  end

  // Output/event decode. ldValid in IDLE is deliberately ignored (stale response).
  always_comb begin
    w_wr_en    = 1'b0;
    w_wr_addr  = 4'd0;
    w_wr_data  = 32'd0;
    w_ld_start = 1'b0;
    w_abort    = 1'b0;
    w_retire   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (isCall) begin
            // Call wins over isWb/isLd: return address goes to RET_REG.
            w_wr_en   = 1'b1;
            w_wr_addr = 4'(RET_REG);
            w_wr_data = PC + 32'd4;
            w_retire  = 1'b1;
          end else if (isWb && !isLd) begin
            w_wr_en   = 1'b1;
            w_wr_addr = instruction[25:22];
            w_wr_data = aluR;
            w_retire  = 1'b1;
          end else if (isWb && isLd) begin
            w_ld_start = 1'b1;
          end else begin
            w_retire = 1'b1;
          end
        end
      end
      S_WAIT_LD: begin
        // Data arriving in the expiry cycle still counts as a normal load write.
        if (ldValid) begin
          w_wr_en   = 1'b1;
          w_wr_addr = r_rd;
          w_wr_data = ldR;
          w_retire  = 1'b1;
        end else if (w_expired) begin
          w_abort  = 1'b1;
          w_retire = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers. Address/data hold their last value between write pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_rd     <= '0;
      r_wb     <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_ld_err <= 1'b0;
      r_ret    <= '0;
    end else begin
      r_wb <= w_wr_en;
      if (w_wr_en) begin
        r_addr <= w_wr_addr;
        r_data <= w_wr_data;
      end
      if (w_ld_start) begin
        r_rd  <= instruction[25:22];
        r_cnt <= '0;
      end else if (r_state == S_WAIT_LD && !ldValid && !w_expired) begin
        r_cnt <= r_cnt + TW'(1);
      end
      if (w_abort)  r_ld_err <= 1'b1;
      if (w_retire) r_ret    <= r_ret + CNT_W'(1);
    end
  end

  assign isWbOut      = r_wb;
  assign writeRegAddr = r_addr;
  assign writeData    = r_data;
  assign ldErr        = r_ld_err;
  assign retCount     = r_ret;

`ifdef WB_FWD_EN
  // Mirrors the write port in the same cycle so operand fetch can bypass the register file.
  assign fwdValid = r_wb;
  assign fwdAddr  = r_addr;
  assign fwdData  = r_data;
`else
  assign fwdValid = 1'b0;
  assign fwdAddr  = 4'd0;
  assign fwdData  = 32'd0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        inValid;
  logic        inReady;
  logic [31:0] instruction;
  logic [31:0] PC;
  logic [31:0] aluR;
  logic        isWb;
  logic        isLd;
  logic        isCall;
  logic        ldValid;
  logic [31:0] ldR;
  logic        isWbOut;
  logic [3:0]  writeRegAddr;
  logic [31:0] writeData;
  logic        fwdValid;
  logic [3:0]  fwdAddr;
  logic [31:0] fwdData;
  logic        ldErr;
  logic [15:0] retCount;

  int checks = 0;
  int errors = 0;

`ifdef WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  wb_stage #(.LD_TIMEOUT(16), .CNT_W(16), .RET_REG(15)) dut (
    .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady), .instruction(instruction),
    .PC(PC), .aluR(aluR), .isWb(isWb), .isLd(isLd), .isCall(isCall), .ldValid(ldValid),
    .ldR(ldR), .isWbOut(isWbOut), .writeRegAddr(writeRegAddr), .writeData(writeData),
    .fwdValid(fwdValid), .fwdAddr(fwdAddr), .fwdData(fwdData), .ldErr(ldErr),
    .retCount(retCount)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inValid = 0; isWb = 0; isLd = 0; isCall = 0; ldValid = 0;
    instruction = 32'h0; PC = 32'h0; aluR = 32'h0; ldR = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; inValid = 1; isWb = 1; aluR = 32'hFFFF_FFFF; instruction = 32'h03C0_0000;
    step(); step();
    rst = 0; idle_inputs();
    checks++; if (isWbOut !== 1'b0)       begin errors++; $display("FAIL rst_wb got %0b exp 0", isWbOut); end
    checks++; if (writeRegAddr !== 4'd0)  begin errors++; $display("FAIL rst_addr got %0d exp 0", writeRegAddr); end
    checks++; if (writeData !== 32'd0)    begin errors++; $display("FAIL rst_data got %h exp 0", writeData); end
    checks++; if (inReady !== 1'b1)       begin errors++; $display("FAIL rst_ready got %0b exp 1", inReady); end
    checks++; if (ldErr !== 1'b0)         begin errors++; $display("FAIL rst_lderr got %0b exp 0", ldErr); end
    checks++; if (retCount !== 16'd0)     begin errors++; $display("FAIL rst_ret got %0d exp 0", retCount); end
    checks++; if ({fwdValid, fwdAddr, fwdData} !== 37'd0) begin errors++; $display("FAIL rst_fwd got %0b/%0d/%h exp 0", fwdValid, fwdAddr, fwdData); end
  endtask

  task automatic test_alu();
    inValid = 1; isWb = 1; instruction = 32'h00C0_0000; aluR = 32'hDEAD_BEEF;  // rd=3
    step(); idle_inputs();
    checks++; if (isWbOut !== 1'b1)            begin errors++; $display("FAIL alu_wb got %0b exp 1", isWbOut); end
    checks++; if (writeRegAddr !== 4'd3)       begin errors++; $display("FAIL alu_addr got %0d exp 3", writeRegAddr); end
    checks++; if (writeData !== 32'hDEAD_BEEF) begin errors++; $display("FAIL alu_data got %h exp deadbeef", writeData); end
    checks++; if (retCount !== 16'd1)          begin errors++; $display("FAIL alu_ret got %0d exp 1", retCount); end
    checks++; if (fwdValid !== FWD)            begin errors++; $display("FAIL alu_fwd_vld got %0b exp %0b", fwdValid, FWD); end
    checks++; if (fwdData !== (FWD ? 32'hDEAD_BEEF : 32'h0)) begin errors++; $display("FAIL alu_fwd_data got %h", fwdData); end
    step();
    checks++; if (isWbOut !== 1'b0)            begin errors++; $display("FAIL alu_pulse got %0b exp 0", isWbOut); end
    checks++; if (writeData !== 32'hDEAD_BEEF) begin errors++; $display("FAIL alu_hold got %h exp deadbeef", writeData); end
  endtask

  task automatic test_call();
    // isWb/isLd also set: call must override them.
    inValid = 1; isCall = 1; isWb = 1; isLd = 1; PC = 32'h0000_0100; instruction = 32'h0040_0000;
    step();
    checks++; if (isWbOut !== 1'b1)      begin errors++; $display("FAIL call_wb got %0b exp 1", isWbOut); end
    checks++; if (writeRegAddr !== 4'd15) begin errors++; $display("FAIL call_addr got %0d exp 15", writeRegAddr); end
    checks++; if (writeData !== 32'h104) begin errors++; $display("FAIL call_data got %h exp 104", writeData); end
    PC = 32'hFFFF_FFFC;  // back-to-back second call, wraps to 0
    step(); idle_inputs();
    checks++; if (isWbOut !== 1'b1)      begin errors++; $display("FAIL call2_wb got %0b exp 1", isWbOut); end
    checks++; if (writeData !== 32'h0)   begin errors++; $display("FAIL call2_wrap got %h exp 0", writeData); end
    checks++; if (retCount !== 16'd3)    begin errors++; $display("FAIL call_ret got %0d exp 3", retCount); end
    checks++; if (inReady !== 1'b1)      begin errors++; $display("FAIL call_ready got %0b exp 1", inReady); end
  endtask

  task automatic test_back_to_back();
    inValid = 1; isWb = 0; instruction = 32'h01C0_0000; aluR = 32'h1111_1111;  // store
    step();
    checks++; if (isWbOut !== 1'b0)      begin errors++; $display("FAIL st_wb got %0b exp 0", isWbOut); end
    checks++; if (retCount !== 16'd4)    begin errors++; $display("FAIL st_ret got %0d exp 4", retCount); end
    checks++; if (writeData !== 32'h0)   begin errors++; $display("FAIL st_hold got %h exp 0", writeData); end
    isWb = 1; aluR = 32'h0000_0055;  // ALU, rd=7
    step(); idle_inputs();
    checks++; if (isWbOut !== 1'b1)      begin errors++; $display("FAIL b2b_wb got %0b exp 1", isWbOut); end
    checks++; if (writeRegAddr !== 4'd7) begin errors++; $display("FAIL b2b_addr got %0d exp 7", writeRegAddr); end
    checks++; if (writeData !== 32'h55)  begin errors++; $display("FAIL b2b_data got %h exp 55", writeData); end
    checks++; if (retCount !== 16'd5)    begin errors++; $display("FAIL b2b_ret got %0d exp 5", retCount); end
  endtask

  task automatic test_load();
    inValid = 1; isWb = 1; isLd = 1; instruction = 32'h0140_0000;  // rd=5
    step(); idle_inputs();
    for (int i = 0; i < 2; i++) begin
      checks++; if (inReady !== 1'b0 || isWbOut !== 1'b0) begin errors++; $display("FAIL ld_wait%0d ready=%0b wb=%0b exp 0/0", i, inReady, isWbOut); end
      step();
    end
    ldValid = 1; ldR = 32'h1234;
    step(); idle_inputs();
    checks++; if (isWbOut !== 1'b1)       begin errors++; $display("FAIL ld_wb got %0b exp 1", isWbOut); end
    checks++; if (writeRegAddr !== 4'd5)  begin errors++; $display("FAIL ld_addr got %0d exp 5", writeRegAddr); end
    checks++; if (writeData !== 32'h1234) begin errors++; $display("FAIL ld_data got %h exp 1234", writeData); end
    checks++; if (retCount !== 16'd6)     begin errors++; $display("FAIL ld_ret got %0d exp 6", retCount); end
    checks++; if (inReady !== 1'b1)       begin errors++; $display("FAIL ld_ready got %0b exp 1", inReady); end
  endtask

  task automatic test_expiry_wins();
    inValid = 1; isWb = 1; isLd = 1; instruction = 32'h0240_0000;  // rd=9
    step(); idle_inputs();
    repeat (15) step();  // now in the 16th wait cycle
    checks++; if (inReady !== 1'b0 || ldErr !== 1'b0) begin errors++; $display("FAIL exp_pre ready=%0b lderr=%0b exp 0/0", inReady, ldErr); end
    ldValid = 1; ldR = 32'hCAFE;
    step(); idle_inputs();
    checks++; if (isWbOut !== 1'b1 || writeRegAddr !== 4'd9 || writeData !== 32'hCAFE) begin errors++; $display("FAIL exp_wr got %0b/%0d/%h exp 1/9/cafe", isWbOut, writeRegAddr, writeData); end
    checks++; if (ldErr !== 1'b0)     begin errors++; $display("FAIL exp_lderr got %0b exp 0", ldErr); end
    checks++; if (retCount !== 16'd7) begin errors++; $display("FAIL exp_ret got %0d exp 7", retCount); end
  endtask

  task automatic test_timeout();
    inValid = 1; isWb = 1; isLd = 1; instruction = 32'h0080_0000;  // rd=2
    step(); idle_inputs();
    repeat (15) step();
    checks++; if (inReady !== 1'b0 || ldErr !== 1'b0) begin errors++; $display("FAIL to_early ready=%0b lderr=%0b exp 0/0", inReady, ldErr); end
    step();  // 16th cycle without data: abort
    checks++; if (ldErr !== 1'b1)     begin errors++; $display("FAIL to_lderr got %0b exp 1", ldErr); end
    checks++; if (isWbOut !== 1'b0)   begin errors++; $display("FAIL to_wb got %0b exp 0", isWbOut); end
    checks++; if (inReady !== 1'b1)   begin errors++; $display("FAIL to_ready got %0b exp 1", inReady); end
    checks++; if (retCount !== 16'd8) begin errors++; $display("FAIL to_ret got %0d exp 8", retCount); end
    ldValid = 1; ldR = 32'hBAD0;
    step(); idle_inputs();
    checks++; if (isWbOut !== 1'b0 || writeData !== 32'hCAFE) begin errors++; $display("FAIL stale_ld got %0b/%h exp 0/cafe", isWbOut, writeData); end
    checks++; if (retCount !== 16'd8 || ldErr !== 1'b1) begin errors++; $display("FAIL stale_state ret=%0d lderr=%0b exp 8/1", retCount, ldErr); end
  endtask

  task automatic test_rst_wait();
    inValid = 1; isWb = 1; isLd = 1; instruction = 32'h0100_0000;  // rd=4
    step(); idle_inputs();
    step();
    rst = 1;
    step();
    rst = 0; ldValid = 1; ldR = 32'h7777;
    step(); idle_inputs();
    checks++; if (isWbOut !== 1'b0 || writeRegAddr !== 4'd0 || writeData !== 32'd0) begin errors++; $display("FAIL rstw_port got %0b/%0d/%h exp 0/0/0", isWbOut, writeRegAddr, writeData); end
    checks++; if (ldErr !== 1'b0 || retCount !== 16'd0) begin errors++; $display("FAIL rstw_state lderr=%0b ret=%0d exp 0/0", ldErr, retCount); end
    checks++; if (inReady !== 1'b1)   begin errors++; $display("FAIL rstw_ready got %0b exp 1", inReady); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_call();
    test_back_to_back();
    test_load();
    test_expiry_wins();
    test_timeout();
    test_rst_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
